// File: rtl/hcsr04_emulator.sv
// HC-SR04 responder: qualifies a trigger pulse, waits the burst delay,
// then drives an echo pulse whose width encodes the programmed distance.
module hcsr04_emulator #(
    parameter int unsigned CLK_PER_US     = 100,
    parameter int unsigned TRIG_MIN_US    = 10,
    parameter int unsigned BURST_DELAY_US = 250,
    parameter int unsigned CM_US          = 58,
    parameter int unsigned MIN_CM         = 2,
    parameter int unsigned MAX_CM         = 400,
    parameter int unsigned TIMEOUT_US     = 38000,
    parameter int unsigned HOLDOFF_US     = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [15:0] distance_cm,
    input  logic        obj_present,
    output logic        echo,
    output logic        busy,
    output logic        meas_done,
    output logic        trig_err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_TRIG  = 3'd1;
    localparam logic [2:0] S_BURST = 3'd2;
    localparam logic [2:0] S_ECHO  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [31:0] PRE_MAX   = 32'(CLK_PER_US - 1);
    localparam logic [31:0] TRIG_MIN  = 32'(TRIG_MIN_US);
    localparam logic [31:0] BURST_US  = 32'(BURST_DELAY_US);
    localparam logic [31:0] HOLD_US   = 32'(HOLDOFF_US);
    localparam logic [31:0] TMO_US    = 32'(TIMEOUT_US);
    localparam logic [31:0] CM_MUL    = 32'(CM_US);
    localparam logic [15:0] MIN_D     = 16'(MIN_CM);
    localparam logic [15:0] MAX_D     = 16'(MAX_CM);

    // Phases entered from an edge-detect cycle count that cycle as elapsed.
    localparam logic [31:0] PRE_ONE = (CLK_PER_US == 1) ? 32'd0 : 32'd1;
    localparam logic [31:0] US_ONE  = (CLK_PER_US == 1) ? 32'd1 : 32'd0;

    logic        trig_s1;
    logic        trig_s2;
    logic        trig_d;
    logic        trig_rise;
    logic        trig_fall;
    logic [2:0]  state;
    logic [31:0] pre;
    logic [31:0] us_cnt;
    logic [31:0] width_us;
    logic [31:0] width_calc;
    logic [31:0] target;
    logic [15:0] dist_cl;
    logic        pre_wrap;
    logic        phase_done;

    assign trig_rise  = trig_s2 & ~trig_d;
    assign trig_fall  = ~trig_s2 & trig_d;
    assign pre_wrap   = (pre == PRE_MAX);
    assign phase_done = pre_wrap && (us_cnt == target - 32'd1);

    always_comb begin
        target = 32'd1;
        unique case (state)
            S_BURST: target = BURST_US;
            S_ECHO:  target = width_us;
            S_HOLD:  target = HOLD_US;
            default: target = 32'd1;
        endcase
    end

    always_comb begin
        dist_cl = (distance_cm < MIN_D) ? MIN_D : distance_cm;
        if (!obj_present || (distance_cm > MAX_D)) begin
            width_calc = TMO_US;
        end else begin
            width_calc = {16'd0, dist_cl} * CM_MUL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_s1   <= 1'b0;
            trig_s2   <= 1'b0;
            trig_d    <= 1'b0;
            state     <= S_IDLE;
            pre       <= 32'd0;
            us_cnt    <= 32'd0;
            width_us  <= 32'd0;
            echo      <= 1'b0;
            busy      <= 1'b0;
            meas_done <= 1'b0;
            trig_err  <= 1'b0;
        end else begin
            trig_s1   <= trigger;
            trig_s2   <= trig_s1;
            trig_d    <= trig_s2;
            meas_done <= 1'b0;
            trig_err  <= 1'b0;

            if (pre_wrap) begin
                pre    <= 32'd0;
                us_cnt <= us_cnt + 32'd1;
            end else begin
                pre    <= pre + 32'd1;
            end

            unique case (state)
                S_IDLE: begin
                    pre    <= 32'd0;
                    us_cnt <= 32'd0;
                    if (trig_rise) begin
                        state  <= S_TRIG;
                        pre    <= PRE_ONE;
                        us_cnt <= US_ONE;
                    end
                end
                S_TRIG: begin
                    if (us_cnt >= TRIG_MIN) begin
                        us_cnt <= us_cnt;
                    end
                    if (trig_fall) begin
                        if (us_cnt >= TRIG_MIN) begin
                            width_us <= width_calc;
                            busy     <= 1'b1;
                            state    <= S_BURST;
                            pre      <= PRE_ONE;
                            us_cnt   <= US_ONE;
                        end else begin
                            trig_err <= 1'b1;
                            state    <= S_IDLE;
                            pre      <= 32'd0;
                            us_cnt   <= 32'd0;
                        end
                    end
                end
                S_BURST: begin
                    if (phase_done) begin
                        echo   <= 1'b1;
                        state  <= S_ECHO;
                        pre    <= 32'd0;
                        us_cnt <= 32'd0;
                    end
                end
                S_ECHO: begin
                    if (phase_done) begin
                        echo      <= 1'b0;
                        meas_done <= 1'b1;
                        state     <= S_HOLD;
                        pre       <= 32'd0;
                        us_cnt    <= 32'd0;
                    end
                end
                S_HOLD: begin
                    if (phase_done) begin
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                        pre    <= 32'd0;
                        us_cnt <= 32'd0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    echo   <= 1'b0;
                    busy   <= 1'b0;
                    pre    <= 32'd0;
                    us_cnt <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hcsr04_emulator.sv
// Randomised bench for hcsr04_emulator against a timing/width reference model.
// Runs with CLK_PER_US=1 and shortened timeout/holdoff to keep runs short.
module tb_hcsr04_emulator;

    localparam int CLK  = 1;
    localparam int TMIN = 10;
    localparam int BD   = 250;
    localparam int CM   = 58;
    localparam int MINC = 2;
    localparam int MAXC = 400;
    localparam int TO   = 3800;
    localparam int HO   = 500;

    logic        clk = 1'b0;
    logic        reset;
    logic        trigger;
    logic [15:0] distance_cm;
    logic        obj_present;
    logic        echo;
    logic        busy;
    logic        meas_done;
    logic        trig_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int n_rise = 0, n_fall = 0, n_brise = 0, n_bfall = 0;
    int n_done = 0, n_err = 0;
    int t_rise = 0, t_fall = 0, t_brise = 0, t_bfall = 0;
    int t_done = 0, t_err = 0;
    logic echo_q = 1'b0;
    logic busy_q = 1'b0;

    hcsr04_emulator #(
        .CLK_PER_US(CLK), .TRIG_MIN_US(TMIN), .BURST_DELAY_US(BD),
        .CM_US(CM), .MIN_CM(MINC), .MAX_CM(MAXC),
        .TIMEOUT_US(TO), .HOLDOFF_US(HO)
    ) dut (
        .clk(clk), .reset(reset), .trigger(trigger),
        .distance_cm(distance_cm), .obj_present(obj_present),
        .echo(echo), .busy(busy), .meas_done(meas_done),
        .trig_err(trig_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        echo_q <= echo;
        busy_q <= busy;
        if (echo && !echo_q) begin n_rise <= n_rise + 1; t_rise <= cyc; end
        if (!echo && echo_q) begin n_fall <= n_fall + 1; t_fall <= cyc; end
        if (busy && !busy_q) begin n_brise <= n_brise + 1; t_brise <= cyc; end
        if (!busy && busy_q) begin n_bfall <= n_bfall + 1; t_bfall <= cyc; end
        if (meas_done) begin n_done <= n_done + 1; t_done <= cyc; end
        if (trig_err) begin n_err <= n_err + 1; t_err <= cyc; end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected echo width in cycles, straight from the ranging rules.
    function automatic int ref_width(input int d, input bit obj);
        if (!obj || d > MAXC) return TO * CLK;
        return ((d < MINC) ? MINC : d) * CM * CLK;
    endfunction

    task automatic pulse_trig(input int w, output int k);
        @(posedge clk);
        #1;
        trigger = 1'b1;
        tick(w);
        trigger = 1'b0;
        k = cyc;
    endtask

    task automatic measure(input int w, input int d, input bit obj, input bit disturb);
        int k, e0, f0, d0, err0, b0, bf0, expw;
        distance_cm = 16'(d);
        obj_present = obj;
        e0 = n_rise; f0 = n_fall; d0 = n_done;
        err0 = n_err; b0 = n_brise; bf0 = n_bfall;
        expw = ref_width(d, obj);
        pulse_trig(w, k);
        tick(4);
        distance_cm = 16'($urandom_range(0, 500));
        obj_present = 1'($urandom);
        if (disturb) begin
            for (int i = 0; i < BD + 50 && n_rise == e0; i++) tick(1);
            tick(expw / 3);
            trigger = 1'b1;
            tick(15);
            trigger = 1'b0;
            distance_cm = 16'($urandom_range(0, 400));
        end
        for (int i = 0; i < BD + expw + 50 && n_fall == f0; i++) tick(1);
        tick(1);
        chk("echo_seen", n_fall - f0, 1);
        chk("echo_rise", t_rise - k, 2 + BD * CLK);
        chk("echo_width", t_fall - t_rise, expw);
        chk("meas_done_cnt", n_done - d0, 1);
        chk("meas_done_cyc", t_done, t_fall);
        chk("busy_rise", t_brise - k, 3);
        if (disturb) begin
            tick(20);
            trigger = 1'b1;
        end
        for (int i = 0; i < HO * CLK + 50 && n_bfall == bf0; i++) tick(1);
        tick(1);
        chk("busy_fall", t_bfall - t_fall, HO * CLK);
        if (disturb) begin
            tick(30);
            trigger = 1'b0;
            tick(BD + 20);
            chk("held_trig_busy", n_brise - b0, 1);
            chk("held_trig_echo", n_rise - e0, 1);
        end
        chk("no_trig_err", n_err - err0, 0);
    endtask

    initial begin
        int k, e0, b0, err0, d0;
        reset = 1'b0;
        trigger = 1'b0;
        distance_cm = 16'd0;
        obj_present = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick(1);
            trigger = 1'($urandom);
            if (i % 5 == 4)
                chk("reset_outs", int'({echo, busy, meas_done, trig_err}), 0);
        end
        trigger = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(BD + 50);
        chk("idle_no_echo", n_rise, 0);
        chk("idle_no_busy", n_brise, 0);
        chk("idle_no_err", n_err, 0);

        measure(10, 60, 1'b1, 1'b0);
        measure(10, 0, 1'b1, 1'b0);
        measure(11, 1, 1'b1, 1'b0);
        measure(12, 401, 1'b1, 1'b0);
        measure(10, 400, 1'b1, 1'b0);
        measure(10, 50, 1'b0, 1'b0);

        // Trigger one cycle short of the minimum.
        e0 = n_rise; b0 = n_brise; err0 = n_err;
        distance_cm = 16'd20;
        obj_present = 1'b1;
        pulse_trig(TMIN * CLK - 1, k);
        tick(5);
        chk("short_err_cnt", n_err - err0, 1);
        chk("short_err_cyc", t_err - k, 3);
        tick(BD + 20);
        chk("short_no_busy", n_brise - b0, 0);
        chk("short_no_echo", n_rise - e0, 0);
        measure(TMIN * CLK, 20, 1'b1, 1'b0);

        measure(11, int'($urandom_range(2, 35)), 1'b1, 1'b1);

        for (int i = 0; i < 6; i++)
            measure(int'($urandom_range(10, 20)), int'($urandom_range(0, 35)),
                    1'($urandom_range(0, 4) != 0), 1'b0);

        // Reset halfway through the echo pulse.
        e0 = n_rise; d0 = n_done;
        distance_cm = 16'd30;
        obj_present = 1'b1;
        pulse_trig(10, k);
        for (int i = 0; i < BD + 50 && n_rise == e0; i++) tick(1);
        chk("rst_echo_started", n_rise - e0, 1);
        tick(ref_width(30, 1'b1) / 2);
        chk("rst_echo_high", int'(echo), 1);
        reset = 1'b0;
        #1;
        chk("rst_echo_async", int'(echo), 0);
        chk("rst_busy_async", int'(busy), 0);
        tick(3);
        reset = 1'b1;
        tick(BD + 50);
        chk("rst_no_done", n_done - d0, 0);
        chk("rst_no_new_echo", n_rise - e0, 1);
        measure(10, 7, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
